// File: rtl/if_id_fetch_buffer_pkg.sv
// ----------------------------------------------------------------------------
// if_id_fetch_buffer_pkg
// Shared definitions for the IF/ID fetch buffer and the downstream decode and
// ID/EX registers.
//   XLEN         : datapath width
//   NOP_INST     : canonical NOP word (addi x0,x0,0)
//   PC_RESET     : PC value presented when no real instruction is held
//   fetch_beat_t : one fetched {pc, inst} pair
// ----------------------------------------------------------------------------
package if_id_fetch_buffer_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_RESET = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_beat_t;

endpackage

// File: rtl/if_id_fetch_buffer_ctrl.sv
// ----------------------------------------------------------------------------
// if_id_fetch_buffer_ctrl
// Occupancy and pointer control for the IF/ID fetch buffer.
//   CLK, RESET   : clock, synchronous active-high reset
//   i_in_valid   : fetch stage offers a beat
//   i_stall      : decode cannot consume this cycle
//   i_flush      : discard everything held and offered
//   o_in_ready   : buffer can accept a beat (registered count only)
//   o_out_valid  : head entry holds a real instruction
//   o_push       : write the offered beat at o_wr_ptr this cycle
//   o_wr_ptr     : write pointer
//   o_rd_ptr     : read pointer (head entry)
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high; ready never depends on valid, stall or flush in the same cycle, and a
// flush (or reset) cancels any transfer that would otherwise happen.
// ----------------------------------------------------------------------------
module if_id_fetch_buffer_ctrl #(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             i_in_valid,
    input  logic             i_stall,
    input  logic             i_flush,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic             o_push,
    output logic [PTR_W-1:0] o_wr_ptr,
    output logic [PTR_W-1:0] o_rd_ptr
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W:0]   r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             w_pop;

    // Ready is a pure function of registered occupancy. When full, a pop in
    // the same cycle does not reopen the input; the one-cycle bubble is the
    // price of keeping stall off the ready path.
    assign o_in_ready  = (r_count != FULL_CNT);
    assign o_out_valid = (r_count != '0);

    assign o_push = i_in_valid && o_in_ready && !i_flush && !RESET;
    assign w_pop  = o_out_valid && !i_stall && !i_flush;

    // DEPTH is a power of two, so natural pointer wrap is modulo DEPTH.
    always_ff @(posedge CLK) begin
        if (RESET || i_flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (o_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({o_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_wr_ptr = r_wr_ptr;
    assign o_rd_ptr = r_rd_ptr;

endmodule

// File: rtl/if_id_fetch_buffer.sv
// ----------------------------------------------------------------------------
// if_id_fetch_buffer
// Elastic {PC, instruction} buffer between instruction memory and decode.
// Holds up to DEPTH (2 or 4) beats in strict FIFO order and presents a NOP
// with PC 0 whenever nothing valid is held.
//   CLK, RESET          : clock, synchronous active-high reset
//   IN_VALID/IN_INST/IN_PC : beat offered by the fetch stage
//   IN_READY            : buffer accepts a beat this cycle
//   STALL               : decode cannot consume this cycle
//   FLUSH               : taken branch/jump, drop held and offered beats
//   OUT_VALID/OUT_INST/OUT_PC : head beat (NOP_INST / 0 when empty)
// Outputs come only from registered state; there is no empty-buffer bypass.
// ----------------------------------------------------------------------------
module if_id_fetch_buffer
    import if_id_fetch_buffer_pkg::*;
#(
    parameter int              DEPTH      = 2,
    parameter logic [XLEN-1:0] P_NOP_INST = NOP_INST
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            IN_VALID,
    input  logic [XLEN-1:0] IN_INST,
    input  logic [XLEN-1:0] IN_PC,
    output logic            IN_READY,
    input  logic            STALL,
    input  logic            FLUSH,
    output logic            OUT_VALID,
    output logic [XLEN-1:0] OUT_INST,
    output logic [XLEN-1:0] OUT_PC
);

    localparam int PTR_W = $clog2(DEPTH);

    logic             w_push;
    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr;
    fetch_beat_t      w_head;

    // Storage is deliberately not reset; occupancy masks stale entries.
    fetch_beat_t      r_mem [DEPTH];

    if_id_fetch_buffer_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ctrl (
        .CLK         (CLK),
        .RESET       (RESET),
        .i_in_valid  (IN_VALID),
        .i_stall     (STALL),
        .i_flush     (FLUSH),
        .o_in_ready  (IN_READY),
        .o_out_valid (OUT_VALID),
        .o_push      (w_push),
        .o_wr_ptr    (w_wr_ptr),
        .o_rd_ptr    (w_rd_ptr)
    );

    // IN_INST/IN_PC are only sampled on an accepted beat, so X on the bus
    // while IN_VALID is low never reaches the array.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= '{pc: IN_PC, inst: IN_INST};
        end
    end

    assign w_head = r_mem[w_rd_ptr];

    // Empty buffer shows a harmless ADDI so decode and the immediate path
    // never act on stale storage.
    assign OUT_INST = OUT_VALID ? w_head.inst : P_NOP_INST;
    assign OUT_PC   = OUT_VALID ? w_head.pc   : PC_RESET;

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
module tb_if_id_fetch_buffer;

    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        logic        exp_valid;
        logic        exp_ready;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } beat_t;

    // ---------------- clock / reset ----------------
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        IN_VALID = 1'b0;
    logic [31:0] IN_INST = '0;
    logic [31:0] IN_PC = '0;
    logic        IN_READY;
    logic        STALL = 1'b0;
    logic        FLUSH = 1'b0;
    logic        OUT_VALID;
    logic [31:0] OUT_INST;
    logic [31:0] OUT_PC;

    always #5 CLK = ~CLK;

    if_id_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_INST   (IN_INST),
        .IN_PC     (IN_PC),
        .IN_READY  (IN_READY),
        .STALL     (STALL),
        .FLUSH     (FLUSH),
        .OUT_VALID (OUT_VALID),
        .OUT_INST  (OUT_INST),
        .OUT_PC    (OUT_PC)
    );

    // ---------------- scoreboard ----------------
    // Reference model: a queue of accepted beats, head at index 0.
    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        ev = (exp_q.size() != 0);
        ei = ev ? exp_q[0].inst : NOP;
        ep = ev ? exp_q[0].pc : 32'h0;
        cmp({tag, ".out_valid"}, 32'(OUT_VALID), 32'(ev));
        cmp({tag, ".in_ready"}, 32'(IN_READY), 32'(exp_q.size() != DEPTH));
        cmp({tag, ".out_inst"}, OUT_INST, ei);
        cmp({tag, ".out_pc"}, OUT_PC, ep);
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge; drives inputs, advances the model
    // across the rising edge, and returns at the next falling edge.
    task automatic cycle(input logic rst, input logic v, input logic [31:0] inst,
                         input logic [31:0] pc, input logic stall, input logic flush);
        logic ready_m;
        logic valid_m;
        RESET    = rst;
        IN_VALID = v;
        IN_INST  = v ? inst : 'x;
        IN_PC    = v ? pc : 'x;
        STALL    = stall;
        FLUSH    = flush;
        ready_m  = (exp_q.size() != DEPTH);
        valid_m  = (exp_q.size() != 0);
        @(posedge CLK);
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (valid_m && !stall) void'(exp_q.pop_front());
            if (v && ready_m) exp_q.push_back('{pc: pc, inst: inst});
        end
        @(negedge CLK);
    endtask

    function automatic vec_t mk(input logic rst, input logic v, input logic [31:0] pc,
                                input logic [31:0] inst, input logic stall, input logic flush,
                                input logic ev, input logic er, input logic [31:0] epc,
                                input logic [31:0] einst);
        vec_t t;
        t.rst = rst; t.valid = v; t.pc = pc; t.inst = inst;
        t.stall = stall; t.flush = flush;
        t.exp_valid = ev; t.exp_ready = er; t.exp_pc = epc; t.exp_inst = einst;
        return t;
    endfunction

    vec_t vecs[$];

    initial begin
        // Expected values describe the outputs after the rising edge that
        // consumes each row's inputs.
        // reset then idle
        vecs.push_back(mk(1,0,0,0,0,0, 0,1,32'h0,NOP));
        vecs.push_back(mk(1,0,0,0,0,0, 0,1,32'h0,NOP));
        vecs.push_back(mk(0,0,0,0,0,0, 0,1,32'h0,NOP));
        // streaming, one per cycle, no gaps
        vecs.push_back(mk(0,1,32'h0,32'h00500093,0,0, 1,1,32'h0,32'h00500093));
        vecs.push_back(mk(0,1,32'h4,32'h00A00113,0,0, 1,1,32'h4,32'h00A00113));
        vecs.push_back(mk(0,1,32'h8,32'h002081B3,0,0, 1,1,32'h8,32'h002081B3));
        vecs.push_back(mk(0,0,0,0,0,0, 0,1,32'h0,NOP));
        // stall fill: third beat held off while full
        vecs.push_back(mk(0,1,32'h0,32'h00500093,1,0, 1,1,32'h0,32'h00500093));
        vecs.push_back(mk(0,1,32'h4,32'h00A00113,1,0, 1,0,32'h0,32'h00500093));
        vecs.push_back(mk(0,1,32'h8,32'h002081B3,1,0, 1,0,32'h0,32'h00500093));
        vecs.push_back(mk(0,1,32'h8,32'h002081B3,0,0, 1,1,32'h4,32'h00A00113));
        vecs.push_back(mk(0,1,32'h8,32'h002081B3,0,0, 1,1,32'h8,32'h002081B3));
        vecs.push_back(mk(0,0,0,0,0,0, 0,1,32'h0,NOP));
        // flush mid-stream drops held and offered beats
        vecs.push_back(mk(0,1,32'h10,32'h11111111,1,0, 1,1,32'h10,32'h11111111));
        vecs.push_back(mk(0,1,32'h14,32'h22222222,1,0, 1,0,32'h10,32'h11111111));
        vecs.push_back(mk(0,1,32'h18,32'h33333333,0,1, 0,1,32'h0,NOP));
        vecs.push_back(mk(0,1,32'h40,32'h00000513,0,0, 1,1,32'h40,32'h00000513));
        vecs.push_back(mk(0,0,0,0,0,0, 0,1,32'h0,NOP));
        // flush beats stall on a full buffer
        vecs.push_back(mk(0,1,32'h20,32'h44444444,1,0, 1,1,32'h20,32'h44444444));
        vecs.push_back(mk(0,1,32'h24,32'h55555555,1,0, 1,0,32'h20,32'h44444444));
        vecs.push_back(mk(0,1,32'h28,32'h66666666,1,1, 0,1,32'h0,NOP));
        // reset while full with a beat offered
        vecs.push_back(mk(0,1,32'h30,32'h77777777,1,0, 1,1,32'h30,32'h77777777));
        vecs.push_back(mk(0,1,32'h34,32'h88888888,1,0, 1,0,32'h30,32'h77777777));
        vecs.push_back(mk(1,1,32'h38,32'h99999999,0,0, 0,1,32'h0,NOP));
        vecs.push_back(mk(0,0,0,0,0,0, 0,1,32'h0,NOP));
        // reset with flush behaves as reset; stall on empty is a no-op
        vecs.push_back(mk(0,1,32'h50,32'hAAAAAAAA,1,0, 1,1,32'h50,32'hAAAAAAAA));
        vecs.push_back(mk(1,1,32'h54,32'hBBBBBBBB,0,1, 0,1,32'h0,NOP));
        vecs.push_back(mk(0,0,0,0,1,0, 0,1,32'h0,NOP));

        @(negedge CLK);
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            cycle(vecs[i].rst, vecs[i].valid, vecs[i].inst, vecs[i].pc,
                  vecs[i].stall, vecs[i].flush);
            cmp({tag, ".out_valid"}, 32'(OUT_VALID), 32'(vecs[i].exp_valid));
            cmp({tag, ".in_ready"}, 32'(IN_READY), 32'(vecs[i].exp_ready));
            cmp({tag, ".out_inst"}, OUT_INST, vecs[i].exp_inst);
            cmp({tag, ".out_pc"}, OUT_PC, vecs[i].exp_pc);
        end

        // Hand sequence: sustained throughput, ten back-to-back beats each
        // appear exactly one cycle after their push.
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 32'hC000_0000 + 32'(i), 32'h100 + 32'(i*4), 0, 0);
            cmp("thru.out_pc", OUT_PC, 32'h100 + 32'(i*4));
            cmp("thru.out_valid", 32'(OUT_VALID), 32'h1);
        end
        cycle(0, 0, 0, 0, 0, 0);
        check_model("thru_drain");

        // Randomized run against the queue model, with occasional flush/reset.
        for (int n = 0; n < 600; n++) begin
            logic        r_v, r_s, r_f, r_r;
            r_v = ($urandom_range(0, 99) < 70);
            r_s = ($urandom_range(0, 99) < 35);
            r_f = ($urandom_range(0, 99) < 5);
            r_r = ($urandom_range(0, 99) < 2);
            cycle(r_r, r_v, $urandom, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, r_s, r_f);
            check_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
